// File: rtl/stream_rr_arbiter_if.sv
// Handshake bundle between N valid/ready producers, the arbiter and one shared consumer.
// Ports: s_vld/s_data/s_rdy (producer side), m_vld/m_data/m_src/m_rdy (consumer side).
// The slave modport is the arbiter's view; master is the surrounding environment's view.
interface stream_rr_arbiter_if #(
    parameter int N = 4,
    parameter int W = 32
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    // Producer side: bit i / slice i belongs to producer i.
    logic [N-1:0]   s_vld;
    logic [N*W-1:0] s_data;
    logic [N-1:0]   s_rdy;

    // Consumer side: one registered beat tagged with its source index.
    logic           m_vld;
    logic [W-1:0]   m_data;
    logic [SW-1:0]  m_src;
    logic           m_rdy;

    modport slave (
        input  s_vld,
        input  s_data,
        output s_rdy,
        output m_vld,
        output m_data,
        output m_src,
        input  m_rdy
    );

    modport master (
        output s_vld,
        output s_data,
        input  s_rdy,
        input  m_vld,
        input  m_data,
        input  m_src,
        output m_rdy
    );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output among N producers,
// with a per-grant burst allowance before priority rotates.
// Ports: clk, rst (async active-high), bus (slave modport of stream_rr_arbiter_if).
// Latency: 1 cycle from producer handshake to m_vld. Backpressure: m_rdy low with a
// held beat drops every s_rdy and freezes the priority state.
module stream_rr_arbiter #(
    parameter int N     = 4,
    parameter int W     = 32,
    parameter int BURST = 1
) (
    input  logic               clk,
    input  logic               rst,
    stream_rr_arbiter_if.slave bus
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    // Counter must hold values up to BURST before the rotate decision.
    localparam int CW = (BURST > 1) ? $clog2(BURST + 1) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SW-1:0] ptr;
    logic [CW-1:0] burst_cnt;
    logic          out_vld;
    logic [W-1:0]  out_data;
    logic [SW-1:0] out_src;

    // ------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------
    logic          accept;
    logic          gnt_found;
    logic [SW-1:0] gnt;
    logic [SW:0]   scan_idx;
    logic [W-1:0]  gnt_data;
    logic          xfer;
    logic [N-1:0]  rdy_vec;
    logic [CW-1:0] new_cnt;
    logic [SW-1:0] ptr_nxt;
    logic [CW-1:0] cnt_nxt;

    // Output register can take a new beat when empty or draining this cycle.
    assign accept = !out_vld || bus.m_rdy;

    // Scan ptr, ptr+1, ... wrapping at N; first requester wins. The extra
    // bit on scan_idx lets the wrap subtract work for non-power-of-2 N.
    always_comb begin
        gnt_found = 1'b0;
        gnt       = '0;
        scan_idx  = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = {1'b0, ptr} + (SW+1)'(k);
            if (scan_idx >= (SW+1)'(N)) begin
                scan_idx = scan_idx - (SW+1)'(N);
            end
            if (!gnt_found && bus.s_vld[scan_idx[SW-1:0]]) begin
                gnt_found = 1'b1;
                gnt       = scan_idx[SW-1:0];
            end
        end
    end

    // Data mux is kept separate from the grant so s_rdy never depends on s_data.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt == SW'(i)) begin
                gnt_data = bus.s_data[i*W +: W];
            end
        end
    end

    assign xfer = accept && gnt_found;

    // One-hot ready toward the granted producer; held low through reset.
    always_comb begin
        rdy_vec = '0;
        if (!rst && xfer) begin
            rdy_vec[gnt] = 1'b1;
        end
    end

    assign bus.s_rdy = rdy_vec;

    // Burst accounting: a win by the pointed-at source extends its run,
    // a win by anyone else starts a fresh run of one beat.
    always_comb begin
        new_cnt = (gnt == ptr) ? (burst_cnt + CW'(1)) : CW'(1);
        if (new_cnt >= CW'(BURST)) begin
            ptr_nxt = (gnt == SW'(N - 1)) ? '0 : (gnt + SW'(1));
            cnt_nxt = '0;
        end else begin
            ptr_nxt = gnt;
            cnt_nxt = new_cnt;
        end
    end

    // ------------------------------------------------------------------
    // Registered output stage and priority state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld   <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
            burst_cnt <= '0;
        end else begin
            if (xfer) begin
                // Fill (possibly while draining): full 1 beat/cycle throughput.
                out_vld   <= 1'b1;
                out_data  <= gnt_data;
                out_src   <= gnt;
                ptr       <= ptr_nxt;
                burst_cnt <= cnt_nxt;
            end else if (out_vld && bus.m_rdy) begin
                // Drain only; data/src keep their last values.
                out_vld <= 1'b0;
            end
        end
    end

    assign bus.m_vld  = out_vld;
    assign bus.m_data = out_data;
    assign bus.m_src  = out_src;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench: two arbiters (BURST=1 and BURST=2, N=4, W=32) on one clock,
// each with its own producer stimulus, checked cycle by cycle against a reference model.
// Directed test-plan steps first, then randomized traffic with random consumer stalls.
module tb_stream_rr_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic m_rdy;
    logic [3:0]  vld [2];
    logic [31:0] dat [2][4];

    always #5 clk = ~clk;

    stream_rr_arbiter_if #(.N(4), .W(32)) bus0 ();
    stream_rr_arbiter_if #(.N(4), .W(32)) bus1 ();

    assign bus0.s_vld  = vld[0];
    assign bus0.s_data = {dat[0][3], dat[0][2], dat[0][1], dat[0][0]};
    assign bus0.m_rdy  = m_rdy;
    assign bus1.s_vld  = vld[1];
    assign bus1.s_data = {dat[1][3], dat[1][2], dat[1][1], dat[1][0]};
    assign bus1.m_rdy  = m_rdy;

    stream_rr_arbiter #(.N(4), .W(32), .BURST(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    stream_rr_arbiter #(.N(4), .W(32), .BURST(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // ---------------- reference model ----------------
    int          brst [2] = '{1, 2};
    int          mptr [2];
    int          mcnt [2];
    int          ms   [2];
    int          acc  [2];   // producer accepted at the last edge, -1 if none
    logic        mv   [2];
    logic [31:0] md   [2];

    int n_chk  = 0;
    int n_fail = 0;

    function automatic int grant(int d);
        for (int k = 0; k < 4; k++) begin
            if (vld[d][(mptr[d] + k) % 4]) return (mptr[d] + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [31:0] exp_rdy(int d);
        int g;
        g = grant(d);
        if (rst || g < 0 || !(!mv[d] || m_rdy)) return 32'd0;
        return 32'd1 << g;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mv[d] = 1'b0; md[d] = 32'd0; ms[d] = 0;
            mptr[d] = 0; mcnt[d] = 0; acc[d] = -1;
        end
    endtask

    task automatic model_edge();
        int g;
        int nc;
        for (int d = 0; d < 2; d++) begin
            g = grant(d);
            acc[d] = -1;
            if (rst) begin
                mv[d] = 1'b0; md[d] = 32'd0; ms[d] = 0; mptr[d] = 0; mcnt[d] = 0;
            end else if ((!mv[d] || m_rdy) && g >= 0) begin
                md[d] = dat[d][g]; ms[d] = g; mv[d] = 1'b1; acc[d] = g;
                nc = (g == mptr[d]) ? mcnt[d] + 1 : 1;
                if (nc >= brst[d]) begin
                    mptr[d] = (g + 1) % 4; mcnt[d] = 0;
                end else begin
                    mptr[d] = g; mcnt[d] = nc;
                end
            end else if (mv[d] && m_rdy) begin
                mv[d] = 1'b0;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, got, exp);
        end
    endtask

    task automatic check_dut(input int d, input logic [3:0] srdy, input logic mvld,
                             input logic [31:0] mdata, input logic [1:0] msrc);
        chk("s_rdy", d, {28'd0, srdy}, exp_rdy(d));
        chk("m_vld", d, {31'd0, mvld}, {31'd0, mv[d]});
        chk("m_data", d, mdata, md[d]);
        chk("m_src", d, {30'd0, msrc}, 32'(ms[d]));
    endtask

    // Called at a negedge after inputs are driven: check, clock, update model.
    task automatic step();
        #1;
        check_dut(0, bus0.s_rdy, bus0.m_vld, bus0.m_data, bus0.m_src);
        check_dut(1, bus1.s_rdy, bus1.m_vld, bus1.m_data, bus1.m_src);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_vld(input logic [3:0] v);
        vld[0] = v;
        vld[1] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
    endtask

    int exp0 [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    int exp1 [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

    initial begin
        rst   = 1'b1;
        m_rdy = 1'b1;
        for (int d = 0; d < 2; d++) begin
            vld[d] = 4'b0000;
            for (int i = 0; i < 4; i++) dat[d][i] = 32'hA0 + 32'(i);
        end
        model_reset();
        @(negedge clk);

        // Reset with all producers requesting: no ready, no output.
        set_vld(4'b1111);
        step();
        step();
        rst = 1'b0;

        // Round-robin and burst sequences, first beat one cycle after first s_rdy.
        #1;
        chk("first_rdy", 0, {28'd0, bus0.s_rdy}, 32'd1);
        chk("first_mvld", 0, {31'd0, bus0.m_vld}, 32'd0);
        for (int k = 0; k < 9; k++) begin
            step();
            chk("seq_vld", 0, {31'd0, bus0.m_vld}, 32'd1);
            chk("seq_src", 0, {30'd0, bus0.m_src}, 32'(exp0[k]));
            chk("seq_src", 1, {30'd0, bus1.m_src}, 32'(exp1[k]));
        end

        // Single requester streams with no bubbles.
        set_vld(4'b0100);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("solo_vld", 1, {31'd0, bus1.m_vld}, 32'd1);
            chk("solo_src", 1, {30'd0, bus1.m_src}, 32'd2);
        end

        // Consumer stall for 5 cycles.
        set_vld(4'b1111);
        step();
        m_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_rdy", 0, {28'd0, bus0.s_rdy}, 32'd0);
            chk("stall_rdy", 1, {28'd0, bus1.s_rdy}, 32'd0);
            step();
        end
        m_rdy = 1'b1;
        for (int k = 0; k < 4; k++) step();

        // Wrap scan from ptr=0 to producer 3, then 0 wins over 3.
        do_reset();
        set_vld(4'b1000);
        #1;
        chk("wrap_rdy", 0, {28'd0, bus0.s_rdy}, 32'd8);
        step();
        set_vld(4'b1001);
        #1;
        chk("wrap_then0", 0, {28'd0, bus0.s_rdy}, 32'd1);
        chk("wrap_burst3", 1, {28'd0, bus1.s_rdy}, 32'd8);
        step();
        step();

        // Producer 1 drops after one beat of a BURST=2 run; 2 gets a full run.
        do_reset();
        set_vld(4'b0001);
        step();
        step();
        set_vld(4'b0110);
        #1;
        chk("drop_g1", 1, {28'd0, bus1.s_rdy}, 32'd2);
        step();
        set_vld(4'b0100);
        #1;
        chk("drop_g2a", 1, {28'd0, bus1.s_rdy}, 32'd4);
        step();
        #1;
        chk("drop_g2b", 1, {28'd0, bus1.s_rdy}, 32'd4);
        step();
        set_vld(4'b0110);
        #1;
        chk("drop_rot", 1, {28'd0, bus1.s_rdy}, 32'd2);
        step();

        // Asynchronous reset while a beat is held under stall.
        set_vld(4'b1111);
        step();
        m_rdy = 1'b0;
        step();
        step();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_mvld", 0, {31'd0, bus0.m_vld}, 32'd0);
        chk("arst_mvld", 1, {31'd0, bus1.m_vld}, 32'd0);
        chk("arst_rdy", 0, {28'd0, bus0.s_rdy}, 32'd0);
        @(negedge clk);
        step();
        rst = 1'b0;
        m_rdy = 1'b1;
        set_vld(4'b1010);
        #1;
        chk("post_rst", 0, {28'd0, bus0.s_rdy}, 32'd2);
        chk("post_rst", 1, {28'd0, bus1.s_rdy}, 32'd2);
        step();
        step();

        // Randomized traffic; producers hold valid/data until accepted.
        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 4; i++) begin
                    if (!(vld[d][i] && acc[d] != i)) begin
                        vld[d][i] = ($urandom_range(0, 99) < 55);
                        dat[d][i] = $urandom;
                    end
                end
            end
            m_rdy = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
